// File: rtl/reaction_round_scheduler.sv
// Multi-round reaction-time game controller.
// Sequences the shared ms timer through NUM_ROUNDS trials (random wait, stimulus,
// reaction measurement), flags false starts and keeps last/best/average results.
// Optional build macro: FALSE_START_RETRY_EN -- a false start retries the round
// instead of recording the MAX_MS penalty.
module reaction_round_scheduler #(
   parameter int unsigned MAX_MS       = 2047,
   parameter int unsigned NUM_ROUNDS   = 4,
   parameter int unsigned MIN_DELAY_MS = 500,
   parameter int unsigned DELAY_BITS   = 10
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          button_pressed,
   input  logic [$clog2(MAX_MS)-1:0]     timer_value,
   output logic                          timer_load,
   output logic [$clog2(MAX_MS)-1:0]     timer_load_value,
   output logic                          timer_up,
   output logic                          timer_enable,
   output logic                          led_on,
   output logic                          foul,
   output logic                          done,
   output logic [$clog2(NUM_ROUNDS)-1:0] round_idx,
   output logic [$clog2(MAX_MS)-1:0]     last_result,
   output logic [$clog2(MAX_MS)-1:0]     best_result,
   output logic [$clog2(MAX_MS)-1:0]     avg_result,
   output logic [3:0]                    foul_count
);

   localparam int unsigned W  = $clog2(MAX_MS);
   localparam int unsigned RW = $clog2(NUM_ROUNDS);
   localparam int unsigned SW = W + RW;
   localparam int unsigned LW = 11;

   typedef enum logic [2:0] {
      S_IDLE, S_ARM, S_WAIT, S_GO_LOAD, S_GO, S_FOUL, S_RECORD, S_DONE
   } state_t;

   state_t          state, next_state;
   logic            btn_q;
   logic            btn_edge;
   logic [LW-1:0]   lfsr;
   logic [W-1:0]    result_q;
   logic [SW-1:0]   sum;
   logic [SW-1:0]   sum_nxt;
   logic            last_round;
   logic            timer_at_max;

   assign btn_edge     = button_pressed & ~btn_q;
   assign sum_nxt      = sum + SW'(result_q);
   assign last_round   = (round_idx == RW'(NUM_ROUNDS - 1));
   assign timer_at_max = (timer_value == W'(MAX_MS));

   // Button history for rising-edge detection; resets high so a held button is not a start.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) btn_q <= 1'b1;
      else       btn_q <= button_pressed;
   end

   // Free-running 11-bit Fibonacci LFSR, x^11 + x^9 + 1.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) lfsr <= 11'h5A5;
      else       lfsr <= {lfsr[LW-2:0], lfsr[10] ^ lfsr[8]};
   end

   // State register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= S_IDLE;
      else       state <= next_state;
   end

   // Next-state logic; a press in WAIT outranks the timer expiring in the same cycle.
   always_comb begin
      next_state = state;
      case (state)
         S_IDLE:    if (btn_edge) next_state = S_ARM;
         S_ARM:     next_state = S_WAIT;
         S_WAIT: begin
            if (btn_edge)                    next_state = S_FOUL;
            else if (timer_value == W'(0))   next_state = S_GO_LOAD;
         end
         S_GO_LOAD: next_state = btn_edge ? S_RECORD : S_GO;
         S_GO:      if (btn_edge || timer_at_max) next_state = S_RECORD;
         S_FOUL: begin
`ifdef FALSE_START_RETRY_EN
            if (btn_edge) next_state = S_ARM;
`else
            if (btn_edge) next_state = S_RECORD;
`endif
         end
         S_RECORD:  next_state = last_round ? S_DONE : S_ARM;
         S_DONE:    if (btn_edge) next_state = S_IDLE;
         default:   next_state = S_IDLE;
      endcase
   end

   // Moore timer/LED controls decoded from the current state.
   always_comb begin
      timer_load       = 1'b0;
      timer_load_value = '0;
      timer_up         = 1'b0;
      timer_enable     = 1'b0;
      led_on           = 1'b0;
      foul             = 1'b0;
      done             = 1'b0;
      case (state)
         S_ARM: begin
            timer_load       = 1'b1;
            timer_load_value = W'(MIN_DELAY_MS) + W'(lfsr[DELAY_BITS-1:0]);
         end
         S_WAIT:    timer_enable = 1'b1;
         S_GO_LOAD: begin
            led_on     = 1'b1;
            timer_load = 1'b1;
         end
         S_GO: begin
            led_on       = 1'b1;
            timer_enable = 1'b1;
            timer_up     = 1'b1;
         end
         S_FOUL:    foul = 1'b1;
         S_DONE:    done = 1'b1;
         default:   ;
      endcase
   end

   // Round statistics. result_q tracks the value RECORD will commit: 0 in GO_LOAD,
   // the live timer in GO (equals MAX_MS on timeout), the penalty in FOUL.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         round_idx   <= '0;
         last_result <= '0;
         best_result <= W'(MAX_MS);
         avg_result  <= '0;
         sum         <= '0;
         foul_count  <= '0;
         result_q    <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (btn_edge) begin
                  round_idx   <= '0;
                  sum         <= '0;
                  foul_count  <= '0;
                  best_result <= W'(MAX_MS);
               end
            end
            S_WAIT: begin
               if (btn_edge && (foul_count != 4'hF)) foul_count <= foul_count + 4'd1;
            end
            S_GO_LOAD: result_q <= '0;
            S_GO:      result_q <= timer_value;
            S_FOUL:    result_q <= W'(MAX_MS);
            S_RECORD: begin
               last_result <= result_q;
               sum         <= sum_nxt;
               if (result_q < best_result) best_result <= result_q;
               if (last_round) avg_result <= W'(sum_nxt >> RW);
               else            round_idx  <= round_idx + RW'(1);
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_reaction_round_scheduler.sv
// Directed bench for reaction_round_scheduler with a 1 clk = 1 ms timer model.
module tb_reaction_round_scheduler;

   localparam int unsigned W  = 11;
   localparam int unsigned RW = 2;

   logic          clk;
   logic          reset;
   logic          button_pressed;
   logic [W-1:0]  timer_value;
   logic          timer_load;
   logic [W-1:0]  timer_load_value;
   logic          timer_up;
   logic          timer_enable;
   logic          led_on;
   logic          foul;
   logic          done;
   logic [RW-1:0] round_idx;
   logic [W-1:0]  last_result;
   logic [W-1:0]  best_result;
   logic [W-1:0]  avg_result;
   logic [3:0]    foul_count;

   logic [10:0]   m_lfsr;
   int            n_checks;
   int            n_errors;

   reaction_round_scheduler dut (
      .clk              (clk),
      .reset            (reset),
      .button_pressed   (button_pressed),
      .timer_value      (timer_value),
      .timer_load       (timer_load),
      .timer_load_value (timer_load_value),
      .timer_up         (timer_up),
      .timer_enable     (timer_enable),
      .led_on           (led_on),
      .foul             (foul),
      .done             (done),
      .round_idx        (round_idx),
      .last_result      (last_result),
      .best_result      (best_result),
      .avg_result       (avg_result),
      .foul_count       (foul_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Millisecond timer model: saturating up/down counter with synchronous load.
   always @(posedge clk or posedge reset) begin
      if (reset)              timer_value <= '0;
      else if (timer_load)    timer_value <= timer_load_value;
      else if (timer_enable) begin
         if (timer_up) timer_value <= (timer_value == 11'd2047) ? timer_value : timer_value + 11'd1;
         else          timer_value <= (timer_value == 11'd0)    ? timer_value : timer_value - 11'd1;
      end
   end

   // Reference LFSR, x^11 + x^9 + 1, seeded 0x5A5.
   always @(posedge clk or posedge reset) begin
      if (reset) m_lfsr <= 11'h5A5;
      else       m_lfsr <= {m_lfsr[9:0], m_lfsr[10] ^ m_lfsr[8]};
   end

   task automatic chk(input string tag, input int unsigned got, input int unsigned exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic press();
      button_pressed = 1'b1;
      tick();
      button_pressed = 1'b0;
      tick();
   endtask

   task automatic wait_led(input string tag);
      int n = 0;
      while (!led_on && n < 4000) begin
         tick();
         n++;
      end
      chk({tag, "_led_rise"}, led_on, 1);
   endtask

   // Press so the edge is seen in GO while the timer reads r.
   task automatic play_round(input string tag, input int r);
      wait_led(tag);
      repeat (r + 1) tick();
      button_pressed = 1'b1;
      tick();
      button_pressed = 1'b0;
      tick();
   endtask

   initial begin
      int n;
      logic [10:0] lf;
      n_checks = 0;
      n_errors = 0;
      button_pressed = 1'b1;
      reset = 1'b1;
      #22;
      chk("rst_state_led", led_on, 0);
      chk("rst_done", done, 0);
      chk("rst_load", timer_load, 0);
      chk("rst_best", best_result, 2047);
      chk("rst_last", last_result, 0);
      chk("rst_round", round_idx, 0);
      chk("rst_avg", avg_result, 0);
      reset = 1'b0;

      // Button held through reset must not start a game.
      repeat (3) tick();
      chk("held_no_start_load", timer_load, 0);
      chk("held_no_start_en", timer_enable, 0);
      button_pressed = 1'b0;
      repeat (2) tick();
      chk("released_idle", timer_enable, 0);

      // Start: exactly one ARM cycle with the LFSR-derived delay.
      button_pressed = 1'b1;
      tick();
      lf = m_lfsr;
      chk("arm_load", timer_load, 1);
      chk("arm_value", timer_load_value, 500 + int'(lf[9:0]));
      button_pressed = 1'b0;
      tick();
      chk("wait_after_arm_load", timer_load, 0);
      chk("wait_after_arm_en", timer_enable, 1);
      chk("wait_dir_down", timer_up, 0);

      // Round 0: 237 ms reaction.
      play_round("r237", 237);
      chk("r237_last", last_result, 237);
      chk("r237_best", best_result, 237);
      chk("r237_round", round_idx, 1);

      // Round 1: press in the same cycle the timer hits zero -> false start.
      n = 0;
      while (!(timer_enable && !timer_up && timer_value == 11'd1) && n < 4000) begin
         tick();
         n++;
      end
      chk("foul_reach_one", timer_value, 1);
      tick();
      button_pressed = 1'b1;
      tick();
      chk("foul_flag", foul, 1);
      chk("foul_led", led_on, 0);
      chk("foul_count1", foul_count, 1);
      chk("foul_timer_off", timer_enable, 0);
      button_pressed = 1'b0;
      tick();
      button_pressed = 1'b1;
      tick();
`ifdef FALSE_START_RETRY_EN
      chk("retry_arm", timer_load, 1);
      chk("retry_round", round_idx, 1);
      chk("retry_last_kept", last_result, 237);
      button_pressed = 1'b0;
      tick();
      play_round("r50", 50);
      chk("r50_last", last_result, 50);
      chk("r50_best", best_result, 50);
      chk("r50_round", round_idx, 2);
      chk("r50_fouls", foul_count, 1);
`else
      button_pressed = 1'b0;
      tick();
      chk("penalty_last", last_result, 2047);
      chk("penalty_best", best_result, 237);
      chk("penalty_round", round_idx, 2);
      chk("penalty_fouls", foul_count, 1);
`endif

      // Round 2: no press until the up-counter saturates.
      wait_led("tmo");
      n = 0;
      while (led_on && n < 2500) begin
         tick();
         n++;
      end
      chk("tmo_led_off", led_on, 0);
      tick();
      chk("tmo_last", last_result, 2047);
      chk("tmo_round", round_idx, 3);

      // Round 3: asynchronous reset while in GO.
      wait_led("rstgo");
      repeat (5) tick();
      chk("rstgo_in_go", timer_up, 1);
      #2 reset = 1'b1;
      #1;
      chk("rstgo_led", led_on, 0);
      chk("rstgo_round", round_idx, 0);
      chk("rstgo_best", best_result, 2047);
      chk("rstgo_done", done, 0);
      chk("rstgo_fouls", foul_count, 0);
      chk("rstgo_en", timer_enable, 0);
      @(negedge clk);
      reset = 1'b0;
      tick();

      // Full game: 300, 200, 400, 100 -> avg 250, best 100.
      press();
      play_round("g300", 300);
      play_round("g200", 200);
      play_round("g400", 400);
      play_round("g100", 100);
      chk("game_done", done, 1);
      chk("game_best", best_result, 100);
      chk("game_avg", avg_result, 250);
      chk("game_last", last_result, 100);
      chk("game_fouls", foul_count, 0);
      chk("game_round", round_idx, 3);
      chk("game_timer_off", timer_enable, 0);

      // DONE -> IDLE keeps stats; next start clears them.
      press();
      chk("idle_done_clear", done, 0);
      chk("idle_best_kept", best_result, 100);
      chk("idle_avg_kept", avg_result, 250);
      button_pressed = 1'b1;
      tick();
      chk("restart_arm", timer_load, 1);
      chk("restart_best", best_result, 2047);
      chk("restart_round", round_idx, 0);
      button_pressed = 1'b0;
      tick();

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
